// File: rtl/gpio_pkg.sv
// gpio_pkg: bridge state encoding, gpio config register indices and sizes
package gpio_pkg;
  typedef enum logic [1:0] {IDLE, REQ, RESP, RELEASE} state_t;
  localparam int GPIO_DIR = 0;
  localparam int GPIO_OUT = 1;
  localparam int GPIO_IN  = 2;
  localparam int GPIO_IE  = 3;
  localparam int GPIO_PUR = 4;
  localparam int GPIO_PDR = 5;
  localparam int NUM_PINS = 8;
  localparam int NUM_CFG  = 6;
endpackage

// File: rtl/apb_gpio_bridge.sv
// apb_gpio_bridge: APB3 completer turning bus transfers into gpio write/read request handshakes
module apb_gpio_bridge #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16,
  parameter int NUM_CFG = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              write,
  output logic              read,
  output logic [2:0]        add_pin_number,
  output logic [2:0]        add_config,
  output logic              data_in,
  input  logic [31:0]       data_out,
  input  logic              write_done,
  input  logic              read_done
);
  import gpio_pkg::*;
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic          is_wr, start, bad_addr, done, expired, unused;
  assign unused = ^{paddr[ADDR_W-1:8], pwdata[31:1]};
  always_comb begin
    start    = psel & penable;
    bad_addr = paddr[7:6] != 2'b00 || int'(paddr[5:3]) >= NUM_CFG;
    done     = is_wr ? write_done : read_done;
    expired  = cnt == CW'(TIMEOUT - 1);
    pready   = state == RESP;
    write    = state == REQ && is_wr;
    read     = state == REQ && !is_wr;
    // RELEASE waits out any lingering done so it cannot complete the next transfer
    state_nx = state == IDLE ? (start ? (bad_addr ? RESP : REQ) : IDLE)
             : state == REQ  ? (done || expired ? RESP : REQ)
             : state == RESP ? RELEASE
             : (write_done || read_done ? RELEASE : IDLE);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state          <= IDLE;
      cnt            <= '0;
      is_wr          <= 1'b0;
      prdata         <= '0;
      pslverr        <= 1'b0;
      add_pin_number <= '0;
      add_config     <= '0;
      data_in        <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= state == REQ ? cnt + 1'b1 : '0;
      if (state == IDLE && start) begin
        {add_config, add_pin_number} <= paddr[5:0];
        data_in <= pwdata[0];
        is_wr   <= pwrite;
        pslverr <= bad_addr;
      end
      if (state == REQ && done) begin
        pslverr <= 1'b0;
        if (!is_wr) prdata <= data_out;
      end else if (state == REQ && expired) begin
        pslverr <= 1'b1;
        prdata  <= '0;
      end
    end
endmodule

// File: tb/tb_apb_gpio_bridge.sv
// tb_apb_gpio_bridge: directed and random APB transfers against a gpio stub and a scoreboard
module tb_apb_gpio_bridge;
  logic        clk = 0, rst = 0;
  logic        psel = 0, penable = 0, pwrite = 0;
  logic [31:0] paddr = 0, pwdata = 0, prdata, data_out;
  logic        pready, pslverr, write, read, data_in, write_done, read_done;
  logic [2:0]  add_pin_number, add_config;
  int passed = 0, total = 0;

  apb_gpio_bridge #(.ADDR_W(32), .TIMEOUT(16), .NUM_CFG(6)) dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .write(write), .read(read), .add_pin_number(add_pin_number), .add_config(add_config),
    .data_in(data_in), .data_out(data_out), .write_done(write_done), .read_done(read_done)
  );

  always #5 clk = ~clk;

  // gpio stub: write acked in the same cycle, read acked one cycle later, optional stale read_done
  logic gmem [8][8];
  logic ack_en = 1, rd_q = 0;
  int   hold_n = 0, hold_cnt = 0;
  assign write_done = ack_en && write;
  assign read_done  = rd_q || hold_cnt != 0;
  assign data_out   = {25'b0, gmem[add_pin_number][add_config], add_config, add_pin_number};
  always @(posedge clk) begin
    if (write && write_done) gmem[add_pin_number][add_config] <= data_in;
    rd_q     <= ack_en && read && !rd_q;
    hold_cnt <= (rd_q && hold_n > 0) ? hold_n : (hold_cnt > 0 ? hold_cnt - 1 : 0);
  end

  int   both_err = 0, wide_err = 0, run = 0, wr_pulses = 0, rd_pulses = 0;
  logic wr_d = 0, rd_d = 0;
  always @(negedge clk) begin
    if (write && read) both_err++;
    run = pready ? run + 1 : 0;
    if (run > 1) wide_err++;
    if (write && !wr_d) wr_pulses++;
    if (read && !rd_d) rd_pulses++;
    wr_d = write;
    rd_d = read;
  end

  // scoreboard: one bit per 6-bit register address
  logic sb [64];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic apb(input logic wr, input logic [7:0] a, input logic d,
                     output logic [31:0] rd, output logic err, output int lat);
    @(negedge clk);
    psel = 1; penable = 0; pwrite = wr; paddr = {24'b0, a}; pwdata = {31'b0, d};
    @(negedge clk);
    penable = 1;
    lat = 1;
    while (!pready && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    rd = prdata;
    err = pslverr;
    if (!pready) lat = -1;
    psel = 0; penable = 0;
  endtask

  function automatic logic [31:0] exp_rd(input logic [5:0] a);
    return {25'b0, sb[a], a};
  endfunction

  initial begin
    logic [31:0] rd;
    logic        err, b;
    logic [5:0]  a, r;
    int          lat, w0, r0;
    for (int i = 0; i < 64; i++) begin
      sb[i] = 0;
      gmem[i / 8][i % 8] = 0;
    end
    repeat (3) @(negedge clk);
    chk("reset_outputs", {prdata, pready, pslverr, write, read, add_pin_number, add_config, data_in},
        {32'b0, 12'b0});
    rst = 1;
    // basic write then read-back
    w0 = wr_pulses;
    apb(1, 8'h0A, 1, rd, err, lat); sb[6'h0A] = 1;
    chk("wr_lat", lat, 3);
    chk("wr_err", err, 0);
    chk("wr_pulse", wr_pulses - w0, 1);
    apb(0, 8'h0A, 0, rd, err, lat);
    chk("rd_lat", lat, 4);
    chk("rd_err", err, 0);
    chk("rd_data", rd, 32'h4A);
    // highest legal config index, then first illegal one and a bad upper address
    apb(1, 8'h2F, 1, rd, err, lat); sb[6'h2F] = 1;
    apb(0, 8'h2F, 0, rd, err, lat);
    chk("cfg5_data", rd, 32'h6F);
    w0 = wr_pulses; r0 = rd_pulses;
    apb(0, 8'h38, 0, rd, err, lat);
    chk("bad_cfg7_lat", lat, 2);
    chk("bad_cfg7_err", err, 1);
    apb(1, 8'h30, 1, rd, err, lat);
    chk("bad_cfg6_err", err, 1);
    apb(0, 8'h80, 0, rd, err, lat);
    chk("bad_hi_lat", lat, 2);
    chk("bad_hi_err", err, 1);
    chk("bad_no_req", (wr_pulses - w0) + (rd_pulses - r0), 0);
    // peripheral never acks
    ack_en = 0;
    apb(0, 8'h11, 0, rd, err, lat);
    chk("to_lat", lat, 18);
    chk("to_err", err, 1);
    chk("to_data", rd, 0);
    chk("to_read_drop", read, 0);
    ack_en = 1;
    // stale read_done holds the bridge in RELEASE before the next transfer
    hold_n = 5;
    apb(0, 8'h0A, 0, rd, err, lat);
    chk("hold_rd_data", rd, 32'h4A);
    hold_n = 0;
    w0 = wr_pulses;
    apb(1, 8'h0A, 0, rd, err, lat); sb[6'h0A] = 0;
    chk("hold_wr_waits", lat > 4, 1);
    chk("hold_wr_err", err, 0);
    chk("hold_wr_pulse", wr_pulses - w0, 1);
    apb(0, 8'h0A, 0, rd, err, lat);
    chk("hold_readback", rd, exp_rd(6'h0A));
    // async reset in the middle of a write request
    ack_en = 0;
    @(negedge clk);
    psel = 1; penable = 0; pwrite = 1; paddr = 32'h01; pwdata = 1;
    @(negedge clk);
    penable = 1;
    repeat (2) @(negedge clk);
    chk("rst_pre_write", write, 1);
    #2 rst = 0;
    #1;
    chk("rst_write_drop", write, 0);
    chk("rst_pready_low", pready, 0);
    @(negedge clk);
    psel = 0; penable = 0; ack_en = 1;
    @(negedge clk);
    rst = 1;
    apb(0, 8'h00, 0, rd, err, lat);
    chk("post_rst_lat", lat, 4);
    chk("post_rst_data", rd, exp_rd(6'h00));
    apb(0, 8'h01, 0, rd, err, lat);
    chk("aborted_wr", rd, exp_rd(6'h01));
    // random legal write/read pairs
    for (int i = 0; i < 64; i++) begin
      a = {3'($urandom_range(5)), 3'($urandom_range(7))};
      r = {3'($urandom_range(5)), 3'($urandom_range(7))};
      b = 1'($urandom);
      apb(1, {2'b0, a}, b, rd, err, lat); sb[a] = b;
      chk("rnd_wr", {lat, 31'b0, err}, {32'd3, 32'd0});
      apb(0, {2'b0, r}, 0, rd, err, lat);
      chk("rnd_rd", {lat, 31'b0, err}, {32'd4, 32'd0});
      chk("rnd_data", rd, exp_rd(r));
    end
    repeat (4) @(negedge clk);
    chk("never_both", both_err, 0);
    chk("pready_width", wide_err, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
